// File: rtl/dtc_array.sv
// Multi-channel digital-to-time converter: each channel outputs a pulse whose length is
// its code times (prescale+1) clk cycles, all channels sharing one tick counter.
module dtc_array #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4,
    parameter int PRESC_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] dtc_in,
    input  logic [WIDTH-1:0]          period,
    input  logic [PRESC_W-1:0]        prescale,
    input  logic                      mode,
    input  logic                      trig,
    input  logic                      stop,
    output logic [CHANNELS-1:0]       dtc_out,
    output logic                      busy,
    output logic                      done
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_count;
    logic [PRESC_W-1:0]   r_presc;
    logic [PRESC_W-1:0]   r_prescale;
    logic [WIDTH-1:0]     r_period;
    logic                 r_mode;
    logic [WIDTH-1:0]     r_code [CHANNELS];
    logic [CHANNELS-1:0]  r_dtc_out;
    logic                 r_done;

    logic                 w_tick;
    logic                 w_end_tick;
    logic [WIDTH-1:0]     w_max_code;

    // NOTE: every variable written here gets a default before the loop, so no latch is inferred.
    always_comb begin
        w_max_code = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (r_code[i] > w_max_code) begin
                w_max_code = r_code[i];
            end
        end
    end

    assign w_tick     = (r_state == S_RUN) && (r_presc == r_prescale);
    // One-shot ends after the longest channel; continuous ends on the latched frame length.
    assign w_end_tick = r_mode ? (r_count == r_period) : (r_count == w_max_code);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_presc    <= '0;
            r_prescale <= '0;
            r_period   <= '0;
            r_mode     <= 1'b0;
            r_dtc_out  <= '0;
            r_done     <= 1'b0;
            // NOTE: the code latch array is only a few flops and must read as zero after reset.
            for (int i = 0; i < CHANNELS; i++) begin
                r_code[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            if (stop) begin
                r_state   <= S_IDLE;
                r_dtc_out <= '0;
            end else if (trig) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    r_code[i] <= dtc_in[i*WIDTH +: WIDTH];
                end
                r_period   <= period;
                r_prescale <= prescale;
                r_mode     <= mode;
                r_count    <= '0;
                r_presc    <= '0;
                r_dtc_out  <= '0;
                r_state    <= S_RUN;
            end else if (r_state == S_RUN) begin
                if (w_tick) begin
                    r_presc <= '0;
                    r_count <= r_count + 1'b1;
                    for (int i = 0; i < CHANNELS; i++) begin
                        r_dtc_out[i] <= (r_count < r_code[i]) && !w_end_tick;
                    end
                    if (w_end_tick) begin
                        r_done <= 1'b1;
                        if (r_mode) begin
                            r_count <= '0;
                            for (int i = 0; i < CHANNELS; i++) begin
                                r_code[i] <= dtc_in[i*WIDTH +: WIDTH];
                            end
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end else begin
                    r_presc <= r_presc + 1'b1;
                end
            end
        end
    end

    assign dtc_out = r_dtc_out;
    assign busy    = (r_state == S_RUN);
    assign done    = r_done;

endmodule

// File: tb/tb_dtc_array.sv
// Directed bench for dtc_array: one-shot vector table measured edge by edge, plus
// sequences for continuous frames, restart, stop, trig+stop and asynchronous reset.
module tb_dtc_array;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] dtc_in;
    logic [7:0]  period;
    logic [3:0]  prescale;
    logic        mode;
    logic        trig;
    logic        stop;
    logic [3:0]  dtc_out;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    int first_hi [4];
    int n_hi     [4];
    int done_at;
    int n_done;

    dtc_array #(.WIDTH(8), .CHANNELS(4), .PRESC_W(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .dtc_in   (dtc_in),
        .period   (period),
        .prescale (prescale),
        .mode     (mode),
        .trig     (trig),
        .stop     (stop),
        .dtc_out  (dtc_out),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // One-shot vector: codes packed ch0 in the low byte; exp_len in clks, ch0 at index 0.
    typedef struct packed {
        logic [31:0]      codes;
        logic [3:0]       presc;
        logic [3:0][15:0] exp_len;
        logic [15:0]      exp_rise;
        logic [15:0]      exp_done;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive trig for exactly one posedge; returns at the negedge after that edge (edge 0).
    task automatic start(input logic [31:0] codes, input logic [3:0] presc,
                         input logic [7:0] per, input logic md);
        @(negedge clk);
        dtc_in   = codes;
        prescale = presc;
        period   = per;
        mode     = md;
        trig     = 1'b1;
        @(negedge clk);
        trig     = 1'b0;
    endtask

    // Sample after each of the next ncyc posedges; k counts edges since the last sample point.
    task automatic measure(input int ncyc);
        for (int c = 0; c < 4; c++) begin
            first_hi[c] = -1;
            n_hi[c]     = 0;
        end
        done_at = -1;
        n_done  = 0;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) begin
                if (dtc_out[c]) begin
                    if (first_hi[c] < 0) first_hi[c] = k;
                    n_hi[c]++;
                end
            end
            if (done) begin
                if (done_at < 0) done_at = k;
                n_done++;
            end
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        v = vecs[idx];
        start(v.codes, v.presc, 8'd0, 1'b0);
        check($sformatf("v%0d busy_after_trig", idx), int'(busy), 1);
        measure(int'(v.exp_done) + 3);
        for (int c = 0; c < 4; c++) begin
            check($sformatf("v%0d ch%0d high_clks", idx, c), n_hi[c], int'(v.exp_len[c]));
            if (v.exp_len[c] != 0)
                check($sformatf("v%0d ch%0d rise_edge", idx, c), first_hi[c], int'(v.exp_rise));
        end
        check($sformatf("v%0d done_edge", idx), done_at, int'(v.exp_done));
        check($sformatf("v%0d done_count", idx), n_done, 1);
        check($sformatf("v%0d busy_end", idx), int'(busy), 0);
    endtask

    initial begin
        vecs[0] = '{32'hFF050100, 4'd0,  {16'd255, 16'd5,   16'd1,   16'd0},   16'd1,  16'd256};
        vecs[1] = '{32'h00000004, 4'd3,  {16'd0,   16'd0,   16'd0,   16'd16},  16'd4,  16'd20};
        vecs[2] = '{32'h00000000, 4'd2,  {16'd0,   16'd0,   16'd0,   16'd0},   16'd1,  16'd3};
        vecs[3] = '{32'h01030702, 4'd1,  {16'd2,   16'd6,   16'd14,  16'd4},   16'd2,  16'd16};
        vecs[4] = '{32'h09000A0A, 4'd15, {16'd144, 16'd0,   16'd160, 16'd160}, 16'd16, 16'd176};

        rst = 1'b1; dtc_in = '0; period = '0; prescale = '0;
        mode = 1'b0; trig = 1'b0; stop = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset dtc_out", int'(dtc_out), 0);
        check("reset busy", int'(busy), 0);
        check("reset done", int'(done), 0);

        for (int i = 0; i < 5; i++) run_vec(i);

        // Continuous mode: three 10-tick frames, new codes loaded after frame 0 apply to frame 2.
        start(32'h000C0903, 4'd0, 8'd9, 1'b1);
        measure(10);
        check("cont f0 ch0", n_hi[0], 3);
        check("cont f0 ch1", n_hi[1], 9);
        check("cont f0 ch2", n_hi[2], 9);
        check("cont f0 ch3", n_hi[3], 0);
        check("cont f0 done_edge", done_at, 10);
        check("cont f0 done_count", n_done, 1);
        dtc_in = 32'h010A0005;
        measure(10);
        check("cont f1 ch0", n_hi[0], 3);
        check("cont f1 ch1", n_hi[1], 9);
        check("cont f1 ch2", n_hi[2], 9);
        check("cont f1 ch3", n_hi[3], 0);
        check("cont f1 done_edge", done_at, 10);
        measure(10);
        check("cont f2 ch0", n_hi[0], 5);
        check("cont f2 ch1", n_hi[1], 0);
        check("cont f2 ch2", n_hi[2], 9);
        check("cont f2 ch3", n_hi[3], 1);
        check("cont f2 done_edge", done_at, 10);
        check("cont busy", int'(busy), 1);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        check("stop busy", int'(busy), 0);
        check("stop dtc_out", int'(dtc_out), 0);
        check("stop done", int'(done), 0);

        // Continuous with period 0: done every tick, outputs never high.
        start(32'h05050505, 4'd0, 8'd0, 1'b1);
        measure(6);
        check("per0 done_count", n_done, 6);
        check("per0 highs", n_hi[0] + n_hi[1] + n_hi[2] + n_hi[3], 0);
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;

        // Restart mid-pulse: outputs drop, count restarts, no done from the aborted run.
        start(32'h000000C8, 4'd0, 8'd0, 1'b0);
        measure(50);
        check("restart pre ch0", n_hi[0], 50);
        check("restart pre done", n_done, 0);
        start(32'h000000C8, 4'd0, 8'd0, 1'b0);
        check("restart drop dtc_out", int'(dtc_out), 0);
        check("restart drop done", int'(done), 0);
        check("restart busy", int'(busy), 1);
        measure(204);
        check("restart rise", first_hi[0], 1);
        check("restart ch0 len", n_hi[0], 200);
        check("restart done_edge", done_at, 201);
        check("restart done_count", n_done, 1);

        // trig and stop in the same clk: stop wins.
        start(32'h000000C8, 4'd0, 8'd0, 1'b0);
        measure(10);
        trig = 1'b1;
        stop = 1'b1;
        @(negedge clk);
        trig = 1'b0;
        stop = 1'b0;
        check("trigstop busy", int'(busy), 0);
        check("trigstop dtc_out", int'(dtc_out), 0);
        check("trigstop done", int'(done), 0);
        measure(5);
        check("trigstop idle highs", n_hi[0], 0);
        check("trigstop idle done", n_done, 0);

        // Asynchronous reset mid-pulse, then a normal run.
        start(32'h000000C8, 4'd0, 8'd0, 1'b0);
        measure(20);
        check("prerst ch0 high", int'(dtc_out[0]), 1);
        #2;
        rst = 1'b1;
        #1;
        check("async rst dtc_out", int'(dtc_out), 0);
        check("async rst busy", int'(busy), 0);
        check("async rst done", int'(done), 0);
        @(negedge clk);
        rst = 1'b0;
        run_vec(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
